// File: rtl/dcim_pkg.sv
// Shared definitions for the DCIM macro and its host-side sequencer:
// default datapath widths, command opcodes and the sequencer state encoding.
package dcim_pkg;

    localparam int INPUT_WIDTH = 144;
    localparam int WEIGHT_BITS = 12;
    localparam int ACC_WIDTH   = 51;

    localparam logic CMD_LOAD_W = 1'b0;
    localparam logic CMD_RUN    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_RESULT
    } host_state_e;

endpackage

// File: rtl/dcim_timeout_cnt.sv
// Clear/enable cycle counter used to bound the wait for op_done.
// expire is high on an enabled cycle in which the count sits at
// TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th enabled cycle after clear.
module dcim_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles; clear has priority over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Expiry flag, only meaningful while the count is enabled.
    always_comb begin
        expire = en && (cnt == LAST);
    end

endmodule

// File: rtl/dcim_host_ctrl.sv
// Host-side sequencer for the DCIM macro: turns LOAD_W commands plus a
// weight stream into we/wa/d_in write cycles, and RUN commands into a
// start_op pulse, a bounded wait for op_done and a valid/ready result.
// Every output is a register loaded from the next-state logic.
module dcim_host_ctrl #(
    parameter int INPUT_WIDTH    = dcim_pkg::INPUT_WIDTH,
    parameter int WEIGHT_BITS    = dcim_pkg::WEIGHT_BITS,
    parameter int ACC_WIDTH      = dcim_pkg::ACC_WIDTH,
    parameter int NUM_WEIGHTS    = 144,
    parameter int ADDR_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_op,
    input  logic                   cmd_wwidth,
    input  logic                   cmd_inwidth,
    input  logic [INPUT_WIDTH-1:0] cmd_xin,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [WEIGHT_BITS-1:0] w_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_WIDTH-1:0]   res_data,
    output logic                   res_timeout,
    output logic                   start_op,
    output logic                   wwidth,
    output logic                   inwidth,
    output logic                   we,
    output logic [ADDR_BITS-1:0]   wa,
    output logic [WEIGHT_BITS-1:0] d_in,
    output logic [INPUT_WIDTH-1:0] xin,
    input  logic [ACC_WIDTH-1:0]   nout,
    input  logic                   op_done
);

    import dcim_pkg::*;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_WEIGHTS - 1);

    host_state_e state_q, state_d;
    logic [ADDR_BITS-1:0]   widx_q, widx_d;
    logic                   we_d;
    logic [ADDR_BITS-1:0]   wa_d;
    logic [WEIGHT_BITS-1:0] d_in_d;
    logic [INPUT_WIDTH-1:0] xin_d;
    logic                   wwidth_d, inwidth_d;
    logic [ACC_WIDTH-1:0]   res_data_d;
    logic                   res_timeout_d;
    logic                   tmr_clr, tmr_en, tmr_expire;

    dcim_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .expire(tmr_expire)
    );

    // Next-state and next-output logic; handshake flags come from the
    // registered ready/valid outputs so they always match what the peer sees.
    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        we_d          = 1'b0;
        wa_d          = wa;
        d_in_d        = d_in;
        xin_d         = xin;
        wwidth_d      = wwidth;
        inwidth_d     = inwidth;
        res_data_d    = res_data;
        res_timeout_d = res_timeout;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_op == CMD_LOAD_W) begin
                        widx_d  = '0;
                        state_d = ST_LOAD;
                    end else begin
                        xin_d     = cmd_xin;
                        wwidth_d  = cmd_wwidth;
                        inwidth_d = cmd_inwidth;
                        state_d   = ST_START;
                    end
                end
            end
            ST_LOAD: begin
                if (w_valid && w_ready) begin
                    we_d   = 1'b1;
                    wa_d   = widx_q;
                    d_in_d = w_data;
                    widx_d = widx_q + ADDR_BITS'(1);
                    if (widx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                tmr_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (op_done) begin
                    res_data_d    = nout;
                    res_timeout_d = 1'b0;
                    state_d       = ST_RESULT;
                end else if (tmr_expire) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (res_valid && res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and all registered outputs; status outputs are a
    // registered decode of the next state so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            cmd_ready   <= 1'b1;
            w_ready     <= 1'b0;
            start_op    <= 1'b0;
            res_valid   <= 1'b0;
            we          <= 1'b0;
            wa          <= '0;
            d_in        <= '0;
            xin         <= '0;
            wwidth      <= 1'b0;
            inwidth     <= 1'b0;
            res_data    <= '0;
            res_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            cmd_ready   <= (state_d == ST_IDLE);
            w_ready     <= (state_d == ST_LOAD);
            start_op    <= (state_d == ST_START);
            res_valid   <= (state_d == ST_RESULT);
            we          <= we_d;
            wa          <= wa_d;
            d_in        <= d_in_d;
            xin         <= xin_d;
            wwidth      <= wwidth_d;
            inwidth     <= inwidth_d;
            res_data    <= res_data_d;
            res_timeout <= res_timeout_d;
        end
    end

endmodule

// File: tb/tb_dcim_host_ctrl.sv
// Self-checking bench for dcim_host_ctrl. Expected writes and results are
// queued when stimulus is driven and compared when the DUT produces them.
module tb_dcim_host_ctrl;

    import dcim_pkg::*;

    localparam int IW = INPUT_WIDTH;
    localparam int WB = WEIGHT_BITS;
    localparam int AW = ACC_WIDTH;
    localparam int NW = 144;
    localparam int AB = 8;
    localparam int TO = 4096;

    typedef logic [159:0] v_t;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready, cmd_op, cmd_wwidth, cmd_inwidth;
    logic [IW-1:0] cmd_xin;
    logic          w_valid, w_ready;
    logic [WB-1:0] w_data;
    logic          res_valid, res_ready, res_timeout;
    logic [AW-1:0] res_data;
    logic          start_op, wwidth, inwidth, we, op_done;
    logic [AB-1:0] wa;
    logic [WB-1:0] d_in;
    logic [IW-1:0] xin;
    logic [AW-1:0] nout;

    dcim_host_ctrl #(
        .INPUT_WIDTH(IW), .WEIGHT_BITS(WB), .ACC_WIDTH(AW),
        .NUM_WEIGHTS(NW), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_wwidth(cmd_wwidth), .cmd_inwidth(cmd_inwidth), .cmd_xin(cmd_xin),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .start_op(start_op), .wwidth(wwidth),
        .inwidth(inwidth), .we(we), .wa(wa), .d_in(d_in), .xin(xin),
        .nout(nout), .op_done(op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input v_t obs, input v_t exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed { logic [AB-1:0] wa; logic [WB-1:0] d; } wr_t;
    typedef struct packed { logic to; logic [AW-1:0] data; } res_t;
    wr_t  wq[$];
    res_t rq[$];

    int unsigned exp_wa   = 0;
    int unsigned wr_total = 0;
    int unsigned cur_run  = 0;
    int unsigned last_run = 0;

    // Output monitor: pops writes/results first, then records handshakes
    // that will complete at the coming rising edge.
    always @(negedge clk) begin
        wr_t  e, ne;
        res_t r;
        if (!rst_n) begin
            wq.delete();
            exp_wa  = 0;
            cur_run = 0;
        end else begin
            if (we || wq.size() != 0) begin
                check("we_timing", v_t'(we), v_t'(wq.size() != 0));
                if (we && wq.size() != 0) begin
                    e = wq.pop_front();
                    check("wa", v_t'(wa), v_t'(e.wa));
                    check("d_in", v_t'(d_in), v_t'(e.d));
                    check("cmd_ready_load", v_t'(cmd_ready), v_t'(e.wa == AB'(NW - 1)));
                    wr_total++;
                end
            end
            if (we) cur_run++;
            else if (cur_run != 0) begin
                last_run = cur_run;
                cur_run  = 0;
            end
            if (res_valid && res_ready) begin
                if (rq.size() == 0) check("res_extra", v_t'(1), v_t'(0));
                else begin
                    r = rq.pop_front();
                    check("res_data", v_t'(res_data), v_t'(r.data));
                    check("res_timeout", v_t'(res_timeout), v_t'(r.to));
                end
            end
            if (cmd_valid && cmd_ready && cmd_op == CMD_LOAD_W) exp_wa = 0;
            if (w_valid && w_ready) begin
                ne.wa = AB'(exp_wa);
                ne.d  = w_data;
                wq.push_back(ne);
                exp_wa++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, v_t'(cmd_ready), v_t'(1));
        check({tag, "_w_ready"}, v_t'(w_ready), v_t'(0));
        check({tag, "_we"}, v_t'(we), v_t'(0));
        check({tag, "_wa"}, v_t'(wa), v_t'(0));
        check({tag, "_d_in"}, v_t'(d_in), v_t'(0));
        check({tag, "_start_op"}, v_t'(start_op), v_t'(0));
        check({tag, "_res_valid"}, v_t'(res_valid), v_t'(0));
        check({tag, "_res_data"}, v_t'(res_data), v_t'(0));
        check({tag, "_res_timeout"}, v_t'(res_timeout), v_t'(0));
        check({tag, "_xin"}, v_t'(xin), v_t'(0));
        check({tag, "_widths"}, v_t'({wwidth, inwidth}), v_t'(0));
    endtask

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input logic op, input logic [IW-1:0] x, input logic ww, input logic iw);
        int n = 0;
        cmd_op = op; cmd_xin = x; cmd_wwidth = ww; cmd_inwidth = iw;
        cmd_valid = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("cmd_handshake_bound", v_t'(0), v_t'(1));
        tick();
        cmd_valid = 1'b0;
    endtask

    function automatic logic [WB-1:0] wdata(input int mode, input int i);
        case (mode)
            0:       return WB'(1);
            1:       return WB'(i * 3 + 5);
            default: return WB'(12'hA5A ^ i);
        endcase
    endfunction

    task automatic load_words(input int mode, input int count, input bit gap);
        int n;
        for (int i = 0; i < count; i++) begin
            w_data  = wdata(mode, i);
            w_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!w_ready && n < 100) begin
                n++;
                @(negedge clk);
            end
            if (n >= 100) check("w_handshake_bound", v_t'(0), v_t'(1));
            tick();
            if (gap) begin
                w_valid = 1'b0;
                tick();
            end
        end
        w_valid = 1'b0;
    endtask

    // delay < 0: no op_done, a timeout abort is expected. delay >= 2:
    // op_done is raised delay cycles after the start_op cycle.
    task automatic run_op(input logic [IW-1:0] x, input logic ww, input logic iw,
                          input int delay, input logic [AW-1:0] nv,
                          input int stall, input bit stale);
        res_t r;
        int   n;
        r.to   = (delay < 0);
        r.data = (delay < 0) ? '0 : nv;
        rq.push_back(r);
        send_cmd(CMD_RUN, x, ww, iw);
        if (stale) begin
            op_done = 1'b1;
            nout    = ~nv;
        end
        @(negedge clk);
        check("start_op_lat", v_t'(start_op), v_t'(1));
        check("xin", v_t'(xin), v_t'(x));
        check("wwidth", v_t'(wwidth), v_t'(ww));
        check("inwidth", v_t'(inwidth), v_t'(iw));
        tick();
        op_done = 1'b0;
        @(negedge clk);
        check("start_op_pulse", v_t'(start_op), v_t'(0));
        check("res_valid_early", v_t'(res_valid), v_t'(0));
        if (delay >= 0) begin
            repeat (delay - 1) @(posedge clk);
            #1;
            op_done = 1'b1;
            nout    = nv;
            @(negedge clk);
            check("res_valid_pre", v_t'(res_valid), v_t'(0));
            tick();
            op_done = 1'b0;
            nout    = AW'({$urandom, $urandom});
            @(negedge clk);
            check("res_valid_lat", v_t'(res_valid), v_t'(1));
        end else begin
            n = 1;
            while (!res_valid && n <= TO + 10) begin
                @(negedge clk);
                n++;
            end
            // start_op cycle, then TO wait cycles, then the result cycle
            check("timeout_lat", v_t'(n), v_t'(TO + 1));
        end
        for (int s = 0; s < stall; s++) begin
            check("bp_res_valid", v_t'(res_valid), v_t'(1));
            check("bp_cmd_ready", v_t'(cmd_ready), v_t'(0));
            check("bp_start_op", v_t'(start_op), v_t'(0));
            check("bp_res_data", v_t'(res_data), v_t'(r.data));
            check("bp_res_timeout", v_t'(res_timeout), v_t'(r.to));
            @(negedge clk);
        end
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check("res_valid_drop", v_t'(res_valid), v_t'(0));
        check("idle_cmd_ready", v_t'(cmd_ready), v_t'(1));
        tick();
    endtask

    task automatic full_load(input int mode, input bit gap, input int exp_run, input string tag);
        int unsigned base;
        send_cmd(CMD_LOAD_W, '0, 1'b0, 1'b0);
        @(negedge clk);
        check({tag, "_cmd_ready_low"}, v_t'(cmd_ready), v_t'(0));
        tick();
        base = wr_total;
        load_words(mode, NW, gap);
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_writes"}, v_t'(wr_total - base), v_t'(NW));
        check({tag, "_run_len"}, v_t'(last_run), v_t'(exp_run));
        check({tag, "_idle"}, v_t'(cmd_ready), v_t'(1));
        tick();
    endtask

    initial begin
        logic [IW-1:0] x1, x2;
        int unsigned base;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_wwidth = 1'b0; cmd_inwidth = 1'b0;
        cmd_xin = '0; w_valid = 1'b0; w_data = '0; res_ready = 1'b0;
        nout = '0; op_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // op_done while idle must not produce a result
        op_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_op_done", v_t'({res_valid, start_op}), v_t'(0));
        end
        tick();
        op_done = 1'b0;
        tick();

        full_load(0, 1'b0, NW, "b2b");

        x1 = '0;
        x1[11:0] = 12'hFFF;
        run_op(x1, 1'b0, 1'b0, 20, 51'h0FFF, 10, 1'b0);

        x2 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        run_op(x2, 1'b1, 1'b1, 5, 51'h7_0123_4567_89AB, 2, 1'b1);

        run_op(x1, 1'b0, 1'b1, -1, 51'h1234, 3, 1'b0);
        run_op(x2, 1'b1, 1'b0, 3, 51'h5_5555_AAAA_0F0F, 0, 1'b0);
        // op_done on the very cycle the timeout would expire
        run_op(x1, 1'b1, 1'b1, TO, 51'h0_00AB_CDEF_0001, 1, 1'b0);

        full_load(1, 1'b1, 1, "gap");

        // reset in the middle of a load
        send_cmd(CMD_LOAD_W, '0, 1'b0, 1'b0);
        base = wr_total;
        load_words(2, 50, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_writes", v_t'(wr_total - base), v_t'(50));
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (3) @(negedge clk);
        tick();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_writes", v_t'(wr_total - base), v_t'(50));
        check("post_rst_cmd_ready", v_t'(cmd_ready), v_t'(1));
        tick();
        full_load(2, 1'b0, NW, "reload");

        check("wq_empty", v_t'(wq.size()), v_t'(0));
        check("rq_empty", v_t'(rq.size()), v_t'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dcim_host_ctrl.md
Name: dcim_host_ctrl

Overview:
Host-side sequencer that drives the DCIM macro's programming and compute interface. It accepts commands and weight words over valid/ready streams and turns them into we/wa/d_in write cycles. It launches MAC operations with start_op, waits for op_done, then returns nout over a valid/ready result stream. It sits between the system bus/DMA and the DCIM top, and replaces the hand-driven stimulus used in bring-up.

Parameters:
INPUT_WIDTH, 144, width of xin vector
WEIGHT_BITS, 12, width of one weight word
ACC_WIDTH, 51, width of nout / result
NUM_WEIGHTS, 144, weight words per LOAD_W command (≤ 2^ADDR_BITS)
ADDR_BITS, 8, width of wa
TIMEOUT_CYCLES, 4096, max cycles from start_op to op_done before abort

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  1  0=LOAD_W, 1=RUN
cmd_wwidth  in  1  weight-width mode for RUN
cmd_inwidth  in  1  input-width mode for RUN
cmd_xin  in  INPUT_WIDTH  input vector for RUN
w_valid  in  1  weight word valid
w_ready  out  1  weight word accepted when valid&ready
w_data  in  WEIGHT_BITS  weight word
res_valid  out  1  result valid
res_ready  in  1  result consumed when valid&ready
res_data  out  ACC_WIDTH  captured nout
res_timeout  out  1  result is a timeout abort
start_op  out  1  to DCIM, one-cycle pulse
wwidth  out  1  to DCIM
inwidth  out  1  to DCIM
we  out  1  to DCIM write enable
wa  out  ADDR_BITS  to DCIM write address
d_in  out  WEIGHT_BITS  to DCIM write data
xin  out  INPUT_WIDTH  to DCIM input vector
nout  in  ACC_WIDTH  from DCIM
op_done  in  1  from DCIM, completion

Behaviour:
- All outputs registered. Reset value of every output is 0, except cmd_ready = 1 (idle). State = IDLE, counters cleared.
- States: IDLE, LOAD, START, WAIT, RESULT.
- IDLE: cmd_ready=1, w_ready=0. On accept of LOAD_W -> LOAD with widx=0. On accept of RUN -> latch cmd_xin/cmd_wwidth/cmd_inwidth into xin/wwidth/inwidth, then -> START.
- LOAD: w_ready=1, cmd_ready=0. Each w accept produces we=1, wa=widx, d_in=w_data in the next cycle. Then widx++. we=0 on cycles with no accept. d_in/wa hold their last values when we=0. After accept of word NUM_WEIGHTS-1 -> IDLE. The final write cycle coincides with the first IDLE cycle.
- START: start_op=1 for exactly one cycle. Timeout counter cleared. -> WAIT.
- WAIT: tcnt increments each cycle.
  - op_done=1: res_data<=nout (sampled the same cycle), res_timeout<=0, -> RESULT.
  - tcnt reaches TIMEOUT_CYCLES-1 without op_done: res_data<=0, res_timeout<=1, -> RESULT.
  - If op_done and timeout fall in the same cycle, op_done wins.
- op_done is sampled only in WAIT. op_done in IDLE/LOAD/START/RESULT is ignored, including a stale level during the start_op cycle.
- RESULT: res_valid=1. res_data/res_timeout stable until res_ready. On accept -> IDLE, res_valid=0 the next cycle.
- xin, wwidth and inwidth hold from RUN accept until the next RUN accept. They are never changed while an operation is in flight.
- Latency:
  - RUN accept to start_op: 1 cycle.
  - op_done to res_valid: 1 cycle.
  - w accept to we: 1 cycle.
- Back-to-back weights: with w_valid held high, NUM_WEIGHTS consecutive we cycles.
- Reset mid-operation: immediate return to reset values. A partial weight load is abandoned with no further we. An in-flight start_op or result is discarded.
- cmd_valid in non-IDLE states: cmd_ready=0 and the command is held by the upstream. w_valid outside LOAD is not accepted.

Decomposition:
- Shared package dcim_pkg:
  - opcode constants CMD_LOAD_W=1'b0, CMD_RUN=1'b1
  - state encoding
  - default widths INPUT_WIDTH/WEIGHT_BITS/ACC_WIDTH, shared with the DCIM top.
- One natural sub-module: dcim_timeout_cnt (clear/enable/expire counter, TIMEOUT_CYCLES param). All other logic is flat in the FSM.

Test Plan:
- Load: LOAD_W then 144 words of 12'h001 with w_valid held high -> we high 144 consecutive cycles, wa 0..143 in order, d_in=12'h001, cmd_ready low until the last write cycle.
- Run: RUN with xin={132'b0,12'hFFF}, wwidth=0, inwidth=0; DCIM model asserts op_done 20 cycles after start_op with nout=51'h0FFF -> exactly one start_op pulse 1 cycle after accept, res_valid 1 cycle after op_done, res_data=51'h0FFF, res_timeout=0.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid -> res_data stable, cmd_ready=0, no start_op. Release -> back to IDLE.
- Timeout: model never asserts op_done -> res_valid after TIMEOUT_CYCLES, res_timeout=1, res_data=0. Then a subsequent RUN completes normally.
- Gapped load: toggle w_valid every other cycle -> we only on the cycle after each accept, wa has no skips, 144 writes total.
- Reset mid-load: assert rst_n=0 after 50 writes -> all outputs 0, cmd_ready=1 after release. A new LOAD_W restarts at wa=0.
